// File: rtl/bpa_beat_sequencer_pkg.sv
// Shared state encoding, sizing and beat-order helpers for the
// carry-bypass adder beat sequencer.
package bpa_beat_sequencer_pkg;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    WAIT,
    UNLOAD
  } seq_state_e;

  localparam int N_DEF = 512;
  localparam int W_DEF = 32;
  localparam int BEATS = N_DEF / W_DEF;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int beats_of(input int n, input int w);
    return n / w;
  endfunction

  // Little-endian: beat k occupies bits [(k+1)w-1 : kw].
  function automatic int beat_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/bpa_beat_counter.sv
// Mod-BEATS_P beat counter with enable, synchronous clear and
// terminal-count flag.
module bpa_beat_counter
  import bpa_beat_sequencer_pkg::*;
#(
  parameter int BEATS_P = 16,
  parameter int CW      = cnt_w(BEATS_P)
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o  = cnt_q == CW'(BEATS_P - 1);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bpa_beat_sequencer.sv
// Serialises wide adder operands in from W-bit beats, waits out the
// adder latency, then streams Sum back out as W-bit beats.
module bpa_beat_sequencer
  import bpa_beat_sequencer_pkg::*;
#(
  parameter int N       = 512,
  parameter int W       = 32,
  parameter int ADD_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         out_cout,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  input  logic [N-1:0] add_sum,
  input  logic         add_cout
);

  localparam int NB = beats_of(N, W);
  localparam int CW = cnt_w(NB);
  localparam int LW = cnt_w(ADD_LAT + 1);

  seq_state_e state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic [N-1:0] res_q, res_d;
  logic rc_q, rc_d;
  logic [LW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] icnt, ocnt;
  logic itc, otc;
  logic in_fire, out_fire;
  logic [NB-1:0][W-1:0] res_v;

  assign in_ready  = !rst &&
                     (state_q == LOAD_A || state_q == LOAD_B);
  assign out_valid = state_q == UNLOAD;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign res_v     = res_q;
  assign out_data  = out_valid ? res_v[ocnt] : '0;
  assign out_last  = out_valid && otc;
  assign out_cout  = out_valid && rc_q;
  assign add_a     = a_q;
  assign add_b     = b_q;

  bpa_beat_counter #(.BEATS_P(NB)) u_in_cnt (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (in_fire),
    .cnt_o (icnt),
    .tc_o  (itc)
  );

  bpa_beat_counter #(.BEATS_P(NB)) u_out_cnt (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (out_fire),
    .cnt_o (ocnt),
    .tc_o  (otc)
  );

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    for (int k = 0; k < NB; k++) begin
      if (in_fire && icnt == CW'(k)) begin
        if (state_q == LOAD_A) begin
          a_d[beat_lsb(k, W) +: W] = in_data;
        end else begin
          b_d[beat_lsb(k, W) +: W] = in_data;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    res_d   = res_q;
    rc_d    = rc_q;
    unique case (state_q)
      LOAD_A: begin
        if (in_fire && itc) state_d = LOAD_B;
      end
      LOAD_B: begin
        if (in_fire && itc) begin
          state_d = WAIT;
          wcnt_d  = '0;
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q + 1'b1;
        // Operands settled ADD_LAT edges ago; Sum is now valid.
        if (wcnt_q == LW'(ADD_LAT)) begin
          res_d   = add_sum;
          rc_d    = add_cout;
          state_d = UNLOAD;
        end
      end
      UNLOAD: begin
        if (out_fire && otc) state_d = LOAD_A;
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      rc_q    <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      rc_q    <= rc_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule
